// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw buttons and tick strobe in, conditioned levels/requests out.
interface btn_conditioner_if #(
  parameter int NBTN = 3
);
  logic [NBTN-1:0] btn;
  logic            tick;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] req;
  logic [NBTN-1:0] overrun;

  // Stimulus side: drives raw buttons and the downstream tick
  modport master (
    output btn, tick,
    input  level, press, req, overrun
  );

  // Conditioner side
  modport slave (
    input  btn, tick,
    output level, press, req, overrun
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button front end: per channel 2-flop sync, debounce counter,
// rising-edge pulse and a request held until the slow-clock tick consumes it.

// One button channel.
module btn_chan #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_req,
  output logic o_overrun
);
  // Channel state is implied by the debounced level and whether the counter is running
  localparam logic [1:0] ST_RELEASED     = 2'b00;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] ST_HELD         = 2'b10;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_s1, r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level, r_press, r_req, r_ovr;
  logic [1:0]       w_state;
  logic             w_diff;

  assign w_state = {r_level, |r_cnt};
  assign w_diff  = r_s2 ^ r_level;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Debounce: level flips only after DB_CYCLES consecutive differing samples
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (w_state)
        ST_RELEASED, ST_HELD: begin
          if (w_diff) r_cnt <= CNT_W'(1);
        end
        ST_PRESS_WAIT, ST_RELEASE_WAIT: begin
          if (!w_diff) begin
            r_cnt <= '0;                 // bounced back, abandon
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
            r_press <= ~r_level;         // pulse only on the 0->1 side
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Request hold/consume with sticky overrun; a same-cycle tick+press keeps req up
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_req <= 1'b0;
      r_ovr <= 1'b0;
    end else if (r_req && i_tick && r_press) begin
      r_req <= 1'b1;
    end else if (r_req && i_tick) begin
      r_req <= 1'b0;
    end else if (r_req && r_press) begin
      r_ovr <= 1'b1;
    end else if (r_press) begin
      r_req <= 1'b1;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_req     = r_req;
  assign o_overrun = r_ovr;
endmodule

module btn_conditioner #(
  parameter int NBTN      = 3,
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic                 CLK,
  input  logic                 RST,
  btn_conditioner_if.slave     bus
);
  logic [NBTN-1:0] w_level, w_press, w_req, w_ovr;

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    btn_chan #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_chan (
      .i_clk     (CLK),
      .i_rst_n   (RST),
      .i_btn     (bus.btn[g]),
      .i_tick    (bus.tick),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_req     (w_req[g]),
      .o_overrun (w_ovr[g])
    );
  end

  assign bus.level   = w_level;
  assign bus.press   = w_press;
  assign bus.req     = w_req;
  assign bus.overrun = w_ovr;
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioner for the board push-buttons that drive the FIFO test top. Each raw button passes through a two-flop synchronizer, a per-button debounce counter and an edge detector. Each debounced press becomes a request that is held until the downstream slow-clock stage acknowledges it with a `tick` strobe. The outputs feed the FIFO's `wReq`/`rReq` inputs, so one physical press yields exactly one FIFO write or read.

## Interface
- `NBTN`, default 3: number of independent button channels.
- `DB_CYCLES`, default 1_000_000: consecutive stable `CLK` cycles required to accept a level change (10 ms at 100 MHz). Legal range is >= 2.
- `CNT_W`, default 20: width of each debounce counter. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- `CLK`  in  1  system clock (100 MHz board clock). All logic is on its rising edge.
- `RST`  in  1  reset, synchronous and active-low. Sampled on the rising edge of `CLK`; 0 means reset.
- `btn`  in  NBTN  raw asynchronous button levels, 1 = pressed.
- `tick`  in  1  one-`CLK`-cycle strobe marking the cycle in which the downstream stage samples `req`.
- `level`  out  NBTN  debounced button level.
- `press`  out  NBTN  one-cycle pulse on each debounced 0->1 transition.
- `req`  out  NBTN  pending request. Held from press until it is consumed by `tick`.
- `overrun`  out  NBTN  sticky flag: a press arrived while the previous request was still pending.

## Operation
- Each channel is independent. No cross-channel priority or interaction.
- **Synchronizer:** `s1 <= btn[i]`, then `s2 <= s1`. Only `s2` is used downstream.
- **Debounce counter:**
  - If `s2 == level[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DB_CYCLES-1 and `s2 != level[i]`, `level[i]` toggles on that edge and the counter clears.
  - Any bounce back to `level[i]` before that point clears the counter, and no toggle occurs.
- **Channel states** (encoded by `level` plus a nonzero counter):
  - RELEASED: level=0, cnt=0.
  - PRESS_WAIT: level=0, cnt>0.
  - HELD: level=1, cnt=0.
  - RELEASE_WAIT: level=1, cnt>0.
  - Transitions: RELEASED->PRESS_WAIT on `s2`=1. PRESS_WAIT->HELD on count expiry. PRESS_WAIT->RELEASED on `s2`=0. The HELD side is symmetric.
- **press:** `press[i]` is 1 for exactly the one cycle in which `level[i]` is first read as 1. The release edge produces no pulse.
- **req update** (per edge, evaluated in priority order):
  1. `req`=1, `tick`=1, `press`=1: `req` stays 1. The new press replaces the consumed one; `overrun` is unchanged.
  2. `req`=1, `tick`=1, `press`=0: `req` <= 0.
  3. `req`=1, `tick`=0, `press`=1: `req` stays 1 and `overrun` <= 1. Presses are not queued.
  4. `req`=0, `press`=1, any `tick`: `req` <= 1. A request not yet visible cannot be consumed in the same cycle.
  5. Otherwise `req` holds.
- **overrun:** once set, it clears only on reset.

## Timing
- Reset (`RST`=0 at an edge): on the following cycle, `level`, `press`, `req`, `overrun`, the sync flops and all counters are 0.
- Reset applied mid-bounce or mid-request discards all state.
- A button held through reset release is treated as a fresh press: `press` fires DB_CYCLES+2 cycles after the first edge with `RST`=1.
- **Press latency:**
  - `btn` goes high and stays stable before edge k.
  - `s2`=1 after edge k+1.
  - `level`=1 and `press`=1 after edge k+1+DB_CYCLES.
  - `req`=1 after edge k+2+DB_CYCLES.
- Release latency is identical, with no `press`.
- **req lifetime:** `req` falls on the edge following the first cycle in which `tick`=1 and `req`=1. Minimum high time is 1 cycle.
- Counter never exceeds DB_CYCLES-1, so there is no wrap-around.
- Pulses shorter than DB_CYCLES cycles, after synchronization, are rejected.

## Test plan
Use NBTN=3, DB_CYCLES=8.
- **Reset:** hold `RST`=0 for 3 cycles with `btn`=3'b111 -> all outputs 0 throughout. After `RST`=1, `press`=3'b111 for one cycle exactly 10 cycles later.
- **Clean press:** `btn[0]` 0->1 and held, `tick`=0 -> `level[0]`=1 and `press[0]`=1 at cycle +10. `req[0]`=1 from cycle +11 and stays 1. Channels 1 and 2 remain 0.
- **Bounce reject:** toggle `btn[1]` with a period of 6 cycles for 60 cycles, then hold at 0 -> `level[1]`, `press[1]` and `req[1]` stay 0 throughout.
- **Handshake:**
  - Press `btn[2]`, then pulse `tick` for 1 cycle 20 cycles after `req[2]` rises -> `req[2]` is 0 on the next cycle.
  - Release and re-press -> a second `req[2]` pulse; `overrun[2]`=0.
- **Overrun:** with `req[0]`=1 and `tick`=0, release and re-press `btn[0]` -> on the second `press[0]`, `overrun[0]`=1 and `req[0]` stays 1. A subsequent `tick` clears `req[0]` but `overrun[0]` stays 1 until reset.
- **Simultaneous events:**
  - `tick`=1 in the same cycle as `press[0]` with `req[0]`=1 -> `req[0]` stays 1 and `overrun[0]` is unchanged.
  - `tick`=1 in the same cycle as `press[1]` with `req[1]`=0 -> `req[1]`=1 on the next cycle.
